// File: rtl/mega_ram_pkg.sv
// mega_ram_pkg: shared encodings for the mega_ram arbiter slice.
//   state_t : arbiter mode (clear sweep or normal run)
//   gnt_t   : which requester owns the RAM port this cycle
package mega_ram_pkg;

  typedef enum logic {
    ST_CLEAR,
    ST_RUN
  } state_t;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_CPU,
    GNT_DMA
  } gnt_t;

  // Width of the DMA starvation counter; wide enough for STARVE_LIMIT up to 255.
  localparam int unsigned WAIT_CNT_W = 8;

endpackage

// File: rtl/mega_ram_clear_seq.sv
// mega_ram_clear_seq: address sequencer for the post-reset RAM zero sweep.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   active    : sweep in progress (arbiter is in its clear state)
//   clr_cnt   : address being cleared this cycle
//   done      : this cycle writes the last RAM address
//   busy      : sweep in progress, exported to the system
module mega_ram_clear_seq #(
  parameter int unsigned ADDR_BUS_WIDTH = 12
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      active,
  output logic [ADDR_BUS_WIDTH-1:0] clr_cnt,
  output logic                      done,
  output logic                      busy
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clr_cnt <= '0;
    end else if (active) begin
      clr_cnt <= clr_cnt + 1'b1;
    end
  end

  assign done = active && (clr_cnt == '1);
  assign busy = active;

endmodule

// File: rtl/mega_ram_arbiter.sv
// mega_ram_arbiter: shares the single data-RAM port between the CPU (priority)
// and a DMA/video requester with a starvation bound; zero-sweeps the RAM
// after reset before granting anyone.
// Ports:
//   clk, rst                          : clock, asynchronous active-high reset
//   cpu_re/cpu_we/cpu_a/cpu_d_in      : CPU request side
//   cpu_d_out, cpu_stall              : CPU read data, CPU not granted
//   dma_req/dma_we/dma_a/dma_d_in     : DMA request side (held until ack)
//   dma_ack, dma_rd_valid, dma_d_out  : DMA grant, read data valid, read data
//   ram_we/ram_a/ram_d_in/ram_d_out   : RAM port
//   busy                              : clear sweep in progress
module mega_ram_arbiter
  import mega_ram_pkg::*;
#(
  parameter int unsigned ADDR_BUS_WIDTH = 12,
  parameter int unsigned DATA_BUS_WIDTH = 8,
  parameter int unsigned CLEAR_ON_RESET = 1,
  parameter int unsigned STARVE_LIMIT   = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cpu_re,
  input  logic                      cpu_we,
  input  logic [ADDR_BUS_WIDTH-1:0] cpu_a,
  input  logic [DATA_BUS_WIDTH-1:0] cpu_d_in,
  output logic [DATA_BUS_WIDTH-1:0] cpu_d_out,
  output logic                      cpu_stall,
  input  logic                      dma_req,
  input  logic                      dma_we,
  input  logic [ADDR_BUS_WIDTH-1:0] dma_a,
  input  logic [DATA_BUS_WIDTH-1:0] dma_d_in,
  output logic                      dma_ack,
  output logic                      dma_rd_valid,
  output logic [DATA_BUS_WIDTH-1:0] dma_d_out,
  output logic                      ram_we,
  output logic [ADDR_BUS_WIDTH-1:0] ram_a,
  output logic [DATA_BUS_WIDTH-1:0] ram_d_in,
  input  logic [DATA_BUS_WIDTH-1:0] ram_d_out,
  output logic                      busy
);

  localparam state_t                RESET_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
  localparam logic [WAIT_CNT_W-1:0] STARVE_MAX  = WAIT_CNT_W'(STARVE_LIMIT);

  state_t                    state;
  state_t                    next_state;
  gnt_t                      gnt;
  logic [WAIT_CNT_W-1:0]     wait_cnt;
  logic [ADDR_BUS_WIDTH-1:0] clr_cnt;
  logic                      clr_done;
  logic                      cpu_acc;
  logic                      force_dma;

  mega_ram_clear_seq #(
    .ADDR_BUS_WIDTH (ADDR_BUS_WIDTH)
  ) u_clear_seq (
    .clk     (clk),
    .rst     (rst),
    .active  (state == ST_CLEAR),
    .clr_cnt (clr_cnt),
    .done    (clr_done),
    .busy    (busy)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RESET_STATE;
    end else begin
      state <= next_state;
    end
  end

  assign cpu_acc   = cpu_re | cpu_we;
  assign force_dma = dma_req && (wait_cnt == STARVE_MAX);

  always_comb begin
    next_state = state;
    gnt        = GNT_NONE;
    ram_we     = 1'b0;
    ram_a      = cpu_a;
    ram_d_in   = '0;
    cpu_stall  = 1'b1;
    dma_ack    = 1'b0;
    // Reset is applied combinationally too so that the RAM sees no write
    // strobe while rst is held, even though the state already reads CLEAR.
    if (rst) begin
      ram_a = '0;
    end else begin
      unique case (state)
        ST_CLEAR: begin
          ram_we = 1'b1;
          ram_a  = clr_cnt;
          if (clr_done) begin
            next_state = ST_RUN;
          end
        end
        ST_RUN: begin
          cpu_stall = 1'b0;
          if (force_dma) begin
            gnt       = GNT_DMA;
            cpu_stall = cpu_acc;
          end else if (cpu_acc) begin
            gnt = GNT_CPU;
          end else if (dma_req) begin
            gnt = GNT_DMA;
          end
          unique case (gnt)
            GNT_CPU: begin
              ram_we   = cpu_we;
              ram_a    = cpu_a;
              ram_d_in = cpu_d_in;
            end
            GNT_DMA: begin
              ram_we   = dma_we;
              ram_a    = dma_a;
              ram_d_in = dma_d_in;
              dma_ack  = 1'b1;
            end
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

  // Starvation counter only runs in RUN; during the sweep a pending DMA
  // request simply waits without accumulating credit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt     <= '0;
      dma_rd_valid <= 1'b0;
    end else begin
      dma_rd_valid <= (gnt == GNT_DMA) && !dma_we;
      if (state == ST_RUN) begin
        if (!dma_req || gnt == GNT_DMA) begin
          wait_cnt <= '0;
        end else if (wait_cnt != STARVE_MAX) begin
          wait_cnt <= wait_cnt + 1'b1;
        end
      end
    end
  end

  assign cpu_d_out = ram_d_out;
  assign dma_d_out = ram_d_out;

endmodule

// File: tb/tb_mega_ram_arbiter.sv
module tb_mega_ram_arbiter;

  localparam int AW    = 4;
  localparam int DW    = 8;
  localparam int SL    = 4;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          cpu_re, cpu_we;
  logic [AW-1:0] cpu_a;
  logic [DW-1:0] cpu_d_in, cpu_d_out;
  logic          cpu_stall;
  logic          dma_req, dma_we;
  logic [AW-1:0] dma_a;
  logic [DW-1:0] dma_d_in, dma_d_out;
  logic          dma_ack, dma_rd_valid;
  logic          ram_we;
  logic [AW-1:0] ram_a;
  logic [DW-1:0] ram_d_in, ram_d_out;
  logic          busy;

  int checks   = 0;
  int failures = 0;

  mega_ram_arbiter #(
    .ADDR_BUS_WIDTH (AW),
    .DATA_BUS_WIDTH (DW),
    .CLEAR_ON_RESET (1),
    .STARVE_LIMIT   (SL)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cpu_re       (cpu_re),
    .cpu_we       (cpu_we),
    .cpu_a        (cpu_a),
    .cpu_d_in     (cpu_d_in),
    .cpu_d_out    (cpu_d_out),
    .cpu_stall    (cpu_stall),
    .dma_req      (dma_req),
    .dma_we       (dma_we),
    .dma_a        (dma_a),
    .dma_d_in     (dma_d_in),
    .dma_ack      (dma_ack),
    .dma_rd_valid (dma_rd_valid),
    .dma_d_out    (dma_d_out),
    .ram_we       (ram_we),
    .ram_a        (ram_a),
    .ram_d_in     (ram_d_in),
    .ram_d_out    (ram_d_out),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // Single-port RAM: synchronous write, 1-cycle synchronous read, old data on RDW.
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (ram_we) mem[ram_a] <= ram_d_in;
    ram_d_out <= mem[ram_a];
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cpu_re = 0; cpu_we = 0; cpu_a = '0; cpu_d_in = '0;
    dma_req = 0; dma_we = 0; dma_a = '0; dma_d_in = '0;
  endtask

  // Checks one full sweep starting in the current cycle, then the first RUN cycle.
  task automatic check_sweep(input string tag);
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      chk({tag, "_busy"},  int'(busy), 1);
      chk({tag, "_we"},    int'(ram_we), 1);
      chk({tag, "_addr"},  int'(ram_a), i);
      chk({tag, "_data"},  int'(ram_d_in), 0);
      chk({tag, "_stall"}, int'(cpu_stall), 1);
      chk({tag, "_ack"},   int'(dma_ack), 0);
      next_cycle();
    end
    @(negedge clk);
    chk({tag, "_done_busy"}, int'(busy), 0);
    chk({tag, "_done_stall"}, int'(cpu_stall), 0);
    next_cycle();
  endtask

  typedef struct {
    logic          cre, cwe;
    logic [AW-1:0] ca;
    logic [DW-1:0] cd;
    logic          dreq, dwe;
    logic [AW-1:0] da;
    logic [DW-1:0] dd;
    logic          e_stall, e_ack, e_we;
    logic [AW-1:0] e_a;
    logic [DW-1:0] e_din;
    logic          e_rdv, chk_c, chk_d;
    logic [DW-1:0] e_rd;
  } vec_t;

  vec_t tbl [12];

  logic [DW-1:0] ref_mem [DEPTH];

  initial begin
    //          cre cwe ca  cd     dreq dwe da dd     stall ack we  a   din    rdv cc cd rd
    tbl[0]  = '{0, 1, 3, 8'hA5, 0, 0, 0, 8'h00, 0, 0, 1, 3, 8'hA5, 0, 0, 0, 8'h00};
    tbl[1]  = '{1, 0, 3, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0, 3, 8'h00, 0, 0, 0, 8'h00};
    tbl[2]  = '{0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0, 0, 8'h00, 0, 1, 0, 8'hA5};
    tbl[3]  = '{0, 0, 0, 8'h00, 1, 0, 3, 8'h00, 0, 1, 0, 3, 8'h00, 0, 0, 0, 8'h00};
    tbl[4]  = '{0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0, 0, 8'h00, 1, 0, 1, 8'hA5};
    tbl[5]  = '{0, 1, 5, 8'h11, 1, 1, 5, 8'h22, 0, 0, 1, 5, 8'h11, 0, 0, 0, 8'h00};
    tbl[6]  = '{0, 0, 5, 8'h00, 1, 1, 5, 8'h22, 0, 1, 1, 5, 8'h22, 0, 0, 0, 8'h00};
    tbl[7]  = '{1, 0, 5, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0, 5, 8'h00, 0, 0, 0, 8'h00};
    tbl[8]  = '{0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0, 0, 8'h00, 0, 1, 0, 8'h22};
    tbl[9]  = '{1, 1, 6, 8'h33, 0, 0, 0, 8'h00, 0, 0, 1, 6, 8'h33, 0, 0, 0, 8'h00};
    tbl[10] = '{0, 0, 0, 8'h00, 1, 0, 6, 8'h00, 0, 1, 0, 6, 8'h00, 0, 0, 0, 8'h00};
    tbl[11] = '{0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0, 0, 8'h00, 1, 0, 1, 8'h33};

    for (int i = 0; i < DEPTH; i++) begin
      mem[i]     = 8'hFF;
      ref_mem[i] = 8'h00;
    end

    // Reset values
    rst = 1'b1;
    idle_inputs();
    cpu_a = 4'h7;
    @(negedge clk);
    chk("rst_ram_we",  int'(ram_we), 0);
    chk("rst_ack",     int'(dma_ack), 0);
    chk("rst_stall",   int'(cpu_stall), 1);
    chk("rst_busy",    int'(busy), 1);
    chk("rst_ram_a",   int'(ram_a), 0);
    chk("rst_ram_din", int'(ram_d_in), 0);
    chk("rst_rdv",     int'(dma_rd_valid), 0);
    next_cycle();
    rst = 1'b0;
    cpu_a = '0;
    check_sweep("sweep1");

    // Reset in the middle of a sweep restarts it from address 0
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    for (int i = 0; i < 9; i++) next_cycle();
    @(negedge clk);
    chk("mid_pre_addr", int'(ram_a), 9);
    next_cycle();
    @(negedge clk);
    chk("mid_pre_addr10", int'(ram_a), 10);
    rst = 1'b1;
    #1;
    chk("mid_rst_we",    int'(ram_we), 0);
    chk("mid_rst_a",     int'(ram_a), 0);
    chk("mid_rst_busy",  int'(busy), 1);
    chk("mid_rst_stall", int'(cpu_stall), 1);
    next_cycle();
    rst = 1'b0;
    check_sweep("sweep2");

    // Directed vector table
    for (int v = 0; v < 12; v++) begin
      cpu_re = tbl[v].cre;   cpu_we = tbl[v].cwe;
      cpu_a = tbl[v].ca;     cpu_d_in = tbl[v].cd;
      dma_req = tbl[v].dreq; dma_we = tbl[v].dwe;
      dma_a = tbl[v].da;     dma_d_in = tbl[v].dd;
      @(negedge clk);
      chk($sformatf("vec%0d_stall", v), int'(cpu_stall), int'(tbl[v].e_stall));
      chk($sformatf("vec%0d_ack", v),   int'(dma_ack),   int'(tbl[v].e_ack));
      chk($sformatf("vec%0d_we", v),    int'(ram_we),    int'(tbl[v].e_we));
      chk($sformatf("vec%0d_a", v),     int'(ram_a),     int'(tbl[v].e_a));
      if (tbl[v].e_we) chk($sformatf("vec%0d_din", v), int'(ram_d_in), int'(tbl[v].e_din));
      chk($sformatf("vec%0d_rdv", v),   int'(dma_rd_valid), int'(tbl[v].e_rdv));
      if (tbl[v].chk_c) chk($sformatf("vec%0d_cpu_rd", v), int'(cpu_d_out), int'(tbl[v].e_rd));
      if (tbl[v].chk_d) chk($sformatf("vec%0d_dma_rd", v), int'(dma_d_out), int'(tbl[v].e_rd));
      next_cycle();
    end
    ref_mem[3] = 8'hA5;
    ref_mem[5] = 8'h22;
    ref_mem[6] = 8'h33;

    // Starvation: CPU read and DMA read both held; CPU x4 then DMA x1, repeating
    idle_inputs();
    cpu_re = 1; cpu_a = 4'h1;
    dma_req = 1; dma_a = 4'h2;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      chk($sformatf("starve%0d_ack", i),   int'(dma_ack),   (i % 5 == 4) ? 1 : 0);
      chk($sformatf("starve%0d_stall", i), int'(cpu_stall), (i % 5 == 4) ? 1 : 0);
      chk($sformatf("starve%0d_a", i),     int'(ram_a),     (i % 5 == 4) ? 2 : 1);
      next_cycle();
    end
    idle_inputs();
    next_cycle();

    // Randomized traffic against a transaction-level model
    begin
      int            starve = 0;
      int            g;
      logic          pc = 0, pd = 0;
      logic [DW-1:0] ec = '0, ed = '0;
      logic          chold = 0, dhold = 0;
      logic          cacc;
      int            r;
      for (int n = 0; n < 400; n++) begin
        if (!chold) begin
          r = int'($urandom_range(0, 9));
          cpu_re = (r < 4);
          cpu_we = (r >= 3 && r < 6);
          cpu_a = 4'($urandom);
          cpu_d_in = 8'($urandom);
        end
        if (!dhold) begin
          dma_req = ($urandom_range(0, 9) < 5);
          dma_we = 1'($urandom_range(0, 1));
          dma_a = 4'($urandom);
          dma_d_in = 8'($urandom);
        end
        @(negedge clk);
        if (pc) chk("rnd_cpu_rd", int'(cpu_d_out), int'(ec));
        chk("rnd_rdv", int'(dma_rd_valid), int'(pd));
        if (pd) chk("rnd_dma_rd", int'(dma_d_out), int'(ed));
        cacc = cpu_re | cpu_we;
        if (dma_req && starve >= SL) g = 2;
        else if (cacc) g = 1;
        else if (dma_req) g = 2;
        else g = 0;
        chk("rnd_stall", int'(cpu_stall), (cacc && g != 1) ? 1 : 0);
        chk("rnd_ack",   int'(dma_ack),   (g == 2) ? 1 : 0);
        chk("rnd_we",    int'(ram_we),    (g == 1) ? int'(cpu_we) : (g == 2) ? int'(dma_we) : 0);
        chk("rnd_a",     int'(ram_a),     (g == 2) ? int'(dma_a) : int'(cpu_a));
        if (g == 1 && cpu_we) chk("rnd_din_cpu", int'(ram_d_in), int'(cpu_d_in));
        if (g == 2 && dma_we) chk("rnd_din_dma", int'(ram_d_in), int'(dma_d_in));
        pc = (g == 1) && !cpu_we;
        ec = ref_mem[cpu_a];
        pd = (g == 2) && !dma_we;
        ed = ref_mem[dma_a];
        if (g == 1 && cpu_we) ref_mem[cpu_a] = cpu_d_in;
        if (g == 2 && dma_we) ref_mem[dma_a] = dma_d_in;
        starve = (!dma_req || g == 2) ? 0 : starve + 1;
        chold = cacc && (g != 1);
        dhold = dma_req && (g != 2);
        next_cycle();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
